// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and the round-robin pick helper for reg_write_arbiter.
// rr_pick works on a fixed maximum width so one function serves any NUM_REQ <= MAX_REQ.
package reg_arb_pkg;

  localparam int unsigned MAX_REQ = 32;
  localparam int unsigned IDX_W   = 5;

  typedef enum logic [1:0] {IDLE, LOAD, ACK} arb_state_t;

  // First request at or after ptr, wrapping at n, skipping masked requesters.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [IDX_W-1:0]   ptr,
    input logic [MAX_REQ-1:0] mask,
    input logic [IDX_W:0]     n
  );
    logic [IDX_W:0]   idx;
    logic [IDX_W-1:0] pick;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = {1'b0, ptr} + (IDX_W+1)'(k);
      if (idx >= n) idx = idx - n;
      if (!found && ((IDX_W+1)'(k) < n) && req[idx[IDX_W-1:0]] && !mask[idx[IDX_W-1:0]]) begin
        pick  = idx[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Request/grant/data bundle between the write requesters and reg_write_arbiter.
interface reg_write_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
);
  import reg_arb_pkg::*;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]       gnt;
  logic                     busy;
  logic [WIDTH-1:0]         q;

  modport master (output req, wdata, input gnt, busy, q);
  modport slave  (input req, wdata, output gnt, busy, q);

endinterface

// File: rtl/reg_write_arbiter_register.sv
// WIDTH-bit load-enabled register with synchronous active-high clear.
module register
  import reg_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_q <= '0;
    else if (i_load) r_q <= i_data;
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin owner of one register's write port: each accepted write is a LOAD
// cycle (data captured) then an ACK cycle (one-hot gnt, q already updated).
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
) (
  input  logic             clk,
  input  logic             reset,
  reg_write_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  arb_state_t         r_state, w_next_state;
  logic [PTR_W-1:0]   r_rr_ptr, w_next_ptr;
  logic [PTR_W-1:0]   r_winner, w_next_winner;
  logic [PTR_W-1:0]   w_after_winner, w_pick_ptr, w_pick;
  logic [MAX_REQ-1:0] w_req_ext, w_mask;
  logic               w_any;
  logic               w_load;
  logic               w_rst;
  logic [NUM_REQ-1:0] w_gnt;
  logic [WIDTH-1:0]   w_wslice [NUM_REQ];
  logic [WIDTH-1:0]   w_load_data;
  logic [WIDTH-1:0]   w_q;

  assign w_after_winner = (r_winner == PTR_W'(NUM_REQ - 1)) ? '0 : r_winner + 1'b1;

  // In ACK the search starts past the current winner and excludes it, so a lone
  // requester that keeps req high gets a one-cycle gap between writes.
  always_comb begin
    w_req_ext              = '0;
    w_req_ext[NUM_REQ-1:0] = bus.req;
    w_mask                 = '0;
    w_pick_ptr             = r_rr_ptr;
    if (r_state == ACK) begin
      w_mask[r_winner] = 1'b1;
      w_pick_ptr       = w_after_winner;
    end
    w_any  = |(w_req_ext & ~w_mask);
    w_pick = PTR_W'(rr_pick(w_req_ext, IDX_W'(w_pick_ptr), w_mask, (IDX_W+1)'(NUM_REQ)));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_winner <= '0;
    end else begin
      r_state  <= w_next_state;
      r_rr_ptr <= w_next_ptr;
      r_winner <= w_next_winner;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_ptr    = r_rr_ptr;
    w_next_winner = r_winner;
    w_load        = 1'b0;
    w_gnt         = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_next_winner = w_pick;
          w_next_state  = LOAD;
        end
      end
      LOAD: begin
        w_load       = 1'b1;
        w_next_state = ACK;
      end
      ACK: begin
        w_gnt[r_winner] = 1'b1;
        w_next_ptr      = w_after_winner;
        if (w_any) begin
          w_next_winner = w_pick;
          w_next_state  = LOAD;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Data is taken from the winner's slice during LOAD, not at arbitration time.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_wslice[i] = bus.wdata[i*WIDTH +: WIDTH];
    end
  end

  assign w_load_data = w_wslice[r_winner];
  assign w_rst       = ~reset;

  register #(.WIDTH(WIDTH)) u_register (
    .i_clk  (clk),
    .i_rst  (w_rst),
    .i_load (w_load),
    .i_data (w_load_data),
    .o_q    (w_q)
  );

  assign bus.gnt  = w_gnt;
  assign bus.busy = (r_state != IDLE);
  assign bus.q    = w_q;

endmodule
